cp_insert: RTL and testbench

Cyclic-prefix inserter sitting directly downstream of `p_to_s` in the OFDM transmit path. It takes the serial time-domain sample stream produced by `p_to_s` (one sample per strobe, N samples per symbol) and buffers each complete symbol in a ping-pong memory. It then emits the symbol prefixed by a copy of its last CP_LEN samples toward the DAC interface, using a valid/ready handshake. Whole symbols are dropped, and flagged, when both banks are busy.

---
 rtl/cp_insert_pkg.sv | 19 +
 rtl/cp_insert_bank_ram.sv | 38 +++
 rtl/cp_insert.sv | 200 ++++++++++++++++++++
 tb/tb_cp_insert.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cp_insert_pkg.sv
// Shared defaults and FSM state types for the cyclic-prefix inserter.
package cp_insert_pkg;

  localparam int unsigned DefWidth = 10;
  localparam int unsigned DefN     = 64;
  localparam int unsigned DefCpLen = 16;

  typedef enum logic {
    StFill,
    StDrop
  } wr_state_e;

  typedef enum logic [1:0] {
    StIdle,
    StCp,
    StBody
  } rd_state_e;

endpackage

// File: rtl/cp_insert_bank_ram.sv
// Two-bank sample store: one synchronous write port, one registered read port.
module cp_bank_ram #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 128,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Sample storage, no reset needed: a bank is only read after being fully written.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register doubles as the output data register; it holds when re_i is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cp_insert.sv
// Cyclic-prefix inserter: ping-pong buffers each symbol, replays its tail as prefix.
module cp_insert
  import cp_insert_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned N      = DefN,
  parameter int unsigned CP_LEN = DefCpLen
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_sync,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sos,
  output logic             o_drop
);

  localparam int unsigned IdxW  = $clog2(N);
  localparam int unsigned RcW   = $clog2(N + CP_LEN);
  localparam int unsigned AddrW = IdxW + 1;

  localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);
  localparam logic [IdxW-1:0] CpStart = IdxW'(N - CP_LEN);
  localparam logic [RcW-1:0]  RcLast  = RcW'(N + CP_LEN - 1);
  localparam logic [RcW-1:0]  RcCp    = RcW'(CP_LEN);

  wr_state_e       wr_state_q, wr_state_d, wr_state_eff;
  logic [IdxW-1:0] wi_q, wi_d, wi_eff;
  logic            wb_q, wb_d;
  logic            drop_q, drop_d;
  logic            we;
  logic [1:0]      full_set;

  rd_state_e       rd_state_q, rd_state_d;
  logic [RcW-1:0]  rc_q, rc_d, rc_inc;
  logic [IdxW-1:0] idx_inc;
  logic            rb_q, rb_d;
  logic            valid_q, valid_d;
  logic            sos_q, sos_d;
  logic            re;
  logic [AddrW-1:0] raddr;
  logic [1:0]      full_clr;
  logic            hs;

  logic [1:0]      full_q, full_d;

  // Writer: fill the current bank, or swallow a whole symbol when it is still full.
  always_comb begin
    wr_state_d   = wr_state_q;
    wi_d         = wi_q;
    wb_d         = wb_q;
    drop_d       = 1'b0;
    we           = 1'b0;
    full_set     = 2'b00;
    // A sync in the same cycle as a sample makes that sample index 0.
    wr_state_eff = i_sync ? StFill : wr_state_q;
    wi_eff       = i_sync ? '0 : wi_q;
    if (i_sync) begin
      wr_state_d = StFill;
      wi_d       = '0;
    end
    if (i_valid) begin
      unique case (wr_state_eff)
        StFill: begin
          if (wi_eff == '0 && full_q[wb_q]) begin
            wr_state_d = StDrop;
            wi_d       = IdxW'(1);
            drop_d     = 1'b1;
          end else begin
            we = 1'b1;
            if (wi_eff == IdxLast) begin
              full_set[wb_q] = 1'b1;
              wb_d           = ~wb_q;
              wi_d           = '0;
            end else begin
              wi_d = wi_eff + IdxW'(1);
            end
          end
        end
        StDrop: begin
          if (wi_eff == IdxLast) begin
            wr_state_d = StFill;
            wi_d       = '0;
          end else begin
            wi_d = wi_eff + IdxW'(1);
          end
        end
        default: wr_state_d = StFill;
      endcase
    end
  end

  // Reader: stream CP tail then body of the full bank; chain into the other bank without a bubble.
  always_comb begin
    rd_state_d = rd_state_q;
    rc_d       = rc_q;
    rb_d       = rb_q;
    valid_d    = valid_q;
    sos_d      = sos_q;
    re         = 1'b0;
    raddr      = {rb_q, CpStart};
    full_clr   = 2'b00;
    hs         = valid_q & i_ready;
    rc_inc     = rc_q + RcW'(1);
    // Output position p maps to bank index (p - CP_LEN) mod N.
    idx_inc    = IdxW'(rc_inc - RcCp);
    unique case (rd_state_q)
      StIdle: begin
        if (full_q[rb_q]) begin
          re         = 1'b1;
          raddr      = {rb_q, CpStart};
          rc_d       = '0;
          valid_d    = 1'b1;
          sos_d      = 1'b1;
          rd_state_d = StCp;
        end
      end
      StCp, StBody: begin
        if (hs) begin
          if (rc_q == RcLast) begin
            full_clr[rb_q] = 1'b1;
            rb_d           = ~rb_q;
            if (full_q[~rb_q]) begin
              re         = 1'b1;
              raddr      = {~rb_q, CpStart};
              rc_d       = '0;
              sos_d      = 1'b1;
              rd_state_d = StCp;
            end else begin
              valid_d    = 1'b0;
              sos_d      = 1'b0;
              rd_state_d = StIdle;
            end
          end else begin
            re         = 1'b1;
            raddr      = {rb_q, idx_inc};
            rc_d       = rc_inc;
            sos_d      = 1'b0;
            rd_state_d = (rc_inc >= RcCp) ? StBody : StCp;
          end
        end
      end
      default: rd_state_d = StIdle;
    endcase
  end

  // Full flags: writer sets its own bank, reader clears the bank it finished.
  always_comb begin
    full_d = (full_q | full_set) & ~full_clr;
  end

  // All control state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_state_q <= StFill;
      wi_q       <= '0;
      wb_q       <= 1'b0;
      drop_q     <= 1'b0;
      rd_state_q <= StIdle;
      rc_q       <= '0;
      rb_q       <= 1'b0;
      valid_q    <= 1'b0;
      sos_q      <= 1'b0;
      full_q     <= 2'b00;
    end else begin
      wr_state_q <= wr_state_d;
      wi_q       <= wi_d;
      wb_q       <= wb_d;
      drop_q     <= drop_d;
      rd_state_q <= rd_state_d;
      rc_q       <= rc_d;
      rb_q       <= rb_d;
      valid_q    <= valid_d;
      sos_q      <= sos_d;
      full_q     <= full_d;
    end
  end

  cp_bank_ram #(
    .Width (WIDTH),
    .Depth (2 * N)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (we),
    .waddr_i ({wb_q, wi_eff}),
    .wdata_i (i_data),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (o_data)
  );

  assign o_valid = valid_q;
  assign o_sos   = sos_q;
  assign o_drop  = drop_q;

endmodule

// File: tb/tb_cp_insert.sv
// Directed bench for cp_insert: scenario table plus hand-written corner sequences.
module tb_cp_insert;

  localparam int W  = 10;
  localparam int NS = 64;
  localparam int CP = 16;
  localparam int SL = NS + CP;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         i_sync = 1'b0;
  logic         i_valid = 1'b0;
  logic [W-1:0] i_data = '0;
  logic         o_valid;
  logic         i_ready = 1'b1;
  logic [W-1:0] o_data;
  logic         o_sos;
  logic         o_drop;

  cp_insert #(
    .WIDTH  (W),
    .N      (NS),
    .CP_LEN (CP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_sync  (i_sync),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_sos   (o_sos),
    .o_drop  (o_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int q_data[$];
  int q_sos[$];
  int valid_cycles;
  int first_valid;
  int drop_cnt;
  int drop_cyc;
  bit stall_prev;
  int prev_data;
  bit tog;
  int mark_val;
  int mark_edge;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && o_valid) chk("hold", int'(o_data), prev_data);
      stall_prev = o_valid && !i_ready;
      prev_data  = int'(o_data);
      if (o_valid) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (o_valid && i_ready) begin
        q_data.push_back(int'(o_data));
        q_sos.push_back(int'(o_sos));
      end
      if (o_drop) begin
        drop_cnt++;
        drop_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog) i_ready = !i_ready;
  endtask

  task automatic clear_mon();
    q_data.delete();
    q_sos.delete();
    valid_cycles = 0;
    first_valid  = -1;
    drop_cnt     = 0;
    drop_cyc     = -1;
    mark_edge    = -1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    i_valid = 1'b0;
    i_sync  = 1'b0;
    tog     = 1'b0;
    i_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    clear_mon();
    tick();
  endtask

  task automatic sync_pulse();
    i_sync = 1'b1;
    tick();
    i_sync = 1'b0;
  endtask

  // Consecutive samples base..base+cnt-1, one per cycle; records the edge accepting mark_val.
  task automatic feed(input int base, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      i_data  = W'(base + i);
      i_valid = 1'b1;
      if (base + i == mark_val) mark_edge = cyc + 1;
      tick();
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget);
    int b;
    b = budget;
    while (q_data.size() < n && b > 0) begin
      tick();
      b--;
    end
  endtask

  function automatic int exp_val(input int base, input int p);
    return (p < CP) ? base + NS - CP + p : base + p - CP;
  endfunction

  task automatic check_stream(input string nm, input int base0, input int nsym);
    int idx;
    for (int s = 0; s < nsym; s++) begin
      for (int p = 0; p < SL; p++) begin
        idx = s * SL + p;
        if (idx < q_data.size()) begin
          chk({nm, "_data"}, q_data[idx], exp_val(base0 + s * NS, p));
          chk({nm, "_sos"}, q_sos[idx], (p == 0) ? 1 : 0);
        end
      end
    end
  endtask

  typedef struct {
    string name;
    int    nsym;
    bit    toggle;
    int    vmin;
    int    vmax;
  } vec_t;

  vec_t vecs[3];

  initial begin
    vecs[0] = '{name: "single",  nsym: 1, toggle: 1'b0, vmin: SL,         vmax: SL};
    vecs[1] = '{name: "b2b",     nsym: 2, toggle: 1'b0, vmin: 2 * SL,     vmax: 2 * SL};
    vecs[2] = '{name: "bkpress", nsym: 1, toggle: 1'b1, vmin: 2 * SL - 1, vmax: 2 * SL};

    // Reset values.
    do_reset();
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_sos", int'(o_sos), 0);
    chk("rst_drop", int'(o_drop), 0);
    chk("rst_data", int'(o_data), 0);

    // Table-driven streaming scenarios.
    for (int v = 0; v < 3; v++) begin
      do_reset();
      tog      = vecs[v].toggle;
      mark_val = NS - 1;
      sync_pulse();
      feed(0, NS * vecs[v].nsym);
      wait_out(SL * vecs[v].nsym, 800);
      repeat (30) tick();
      tog = 1'b0;
      chk({vecs[v].name, "_count"}, q_data.size(), SL * vecs[v].nsym);
      check_stream(vecs[v].name, 0, vecs[v].nsym);
      chk({vecs[v].name, "_drops"}, drop_cnt, 0);
      chk({vecs[v].name, "_latency"}, first_valid, mark_edge + 1);
      chk({vecs[v].name, "_span"},
          (valid_cycles >= vecs[v].vmin && valid_cycles <= vecs[v].vmax) ? 1 : 0, 1);
    end

    // Overflow: three symbols with output stalled; the third is dropped.
    do_reset();
    i_ready  = 1'b0;
    mark_val = 2 * NS;
    sync_pulse();
    feed(0, 3 * NS);
    repeat (8) tick();
    chk("ovf_drop_cnt", drop_cnt, 1);
    chk("ovf_drop_cyc", drop_cyc, mark_edge);
    chk("ovf_stalled", q_data.size(), 0);
    i_ready = 1'b1;
    wait_out(2 * SL, 400);
    repeat (30) tick();
    chk("ovf_count", q_data.size(), 2 * SL);
    check_stream("ovf", 0, 2);

    // Resync: a partial symbol is abandoned.
    do_reset();
    mark_val = 100 + NS - 1;
    sync_pulse();
    feed(0, 10);
    sync_pulse();
    feed(100, NS);
    wait_out(SL, 400);
    repeat (30) tick();
    chk("resync_count", q_data.size(), SL);
    check_stream("resync", 100, 1);
    chk("resync_latency", first_valid, mark_edge + 1);

    // Asynchronous reset during body output.
    do_reset();
    mark_val = -1;
    sync_pulse();
    feed(0, NS);
    wait_out(30, 400);
    chk("mid_reached", (q_data.size() >= 30) ? 1 : 0, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_valid", int'(o_valid), 0);
    chk("mid_data", int'(o_data), 0);
    chk("mid_sos", int'(o_sos), 0);
    chk("mid_drop", int'(o_drop), 0);
    repeat (3) tick();
    reset = 1'b1;
    clear_mon();
    repeat (200) tick();
    chk("post_rst_out", q_data.size(), 0);
    chk("post_rst_valid", valid_cycles, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
